// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: control FSM for the number-guessing datapath.
// The first enter captures the secret number (ld_actual with ld_guess). Each later enter
// loads a guess. The FSM then latches the comparator result and counts the attempt. The
// game ends on a win, or when MAX_ATTEMPTS is reached (MAX_ATTEMPTS=0 means no limit).
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   enter_i      debounced guess-submit level; only its rising edge advances the FSM
//   cmp_gt_i     datapath: guess > actual
//   cmp_lt_i     datapath: guess < actual
//   cmp_eq_i     datapath: guess == actual
//   ld_actual_o  one-cycle pulse, copy counter into actual register
//   ld_guess_o   one-cycle pulse, copy switches into guess register
//   dp_over_o    last latched result: guess too high
//   dp_under_o   last latched result: guess too low
//   dp_equal_o   last latched result: guess correct
//   attempts_o   completed comparisons this game (saturating)
//   game_over_o  high in win or lose
//   lose_o       high in lose only
//   err_o        sticky: comparator flags were not one-hot when sampled
module guess_game_ctrl #(
    parameter int unsigned MAX_ATTEMPTS = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enter_i,
    input  logic             cmp_gt_i,
    input  logic             cmp_lt_i,
    input  logic             cmp_eq_i,
    output logic             ld_actual_o,
    output logic             ld_guess_o,
    output logic             dp_over_o,
    output logic             dp_under_o,
    output logic             dp_equal_o,
    output logic [CNT_W-1:0] attempts_o,
    output logic             game_over_o,
    output logic             lose_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StLoad  = 3'd1,
        StGuess = 3'd2,
        StCmp   = 3'd3,
        StWait  = 3'd4,
        StWin   = 3'd5,
        StLose  = 3'd6
    } state_e;

    localparam logic [CNT_W:0]   MaxCnt = (CNT_W + 1)'(MAX_ATTEMPTS);
    localparam logic [CNT_W-1:0] SatCnt = '1;

    state_e           state_q, state_d;
    logic             enter_q;
    logic             over_q, over_d;
    logic             under_q, under_d;
    logic             equal_q, equal_d;
    logic [CNT_W-1:0] attempts_q, attempts_d;
    logic             err_q, err_d;

    logic             rise;
    logic [2:0]       flags;
    logic             flags_onehot;
    logic [CNT_W:0]   att_inc;
    logic [CNT_W-1:0] att_next;
    logic             hit_max;

    assign rise         = enter_i & ~enter_q;
    assign flags        = {cmp_gt_i, cmp_lt_i, cmp_eq_i};
    assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    // One bit wider so the limit compare cannot alias when the counter is full.
    assign att_inc      = {1'b0, attempts_q} + {{CNT_W{1'b0}}, 1'b1};
    assign att_next     = (attempts_q == SatCnt) ? attempts_q : att_inc[CNT_W-1:0];
    assign hit_max      = (MAX_ATTEMPTS != 0) && (att_inc == MaxCnt);

    always_comb begin
        state_d     = state_q;
        over_d      = over_q;
        under_d     = under_q;
        equal_d     = equal_q;
        attempts_d  = attempts_q;
        err_d       = err_q;
        ld_actual_o = 1'b0;
        ld_guess_o  = 1'b0;
        case (state_q)
            StInit: begin
                if (rise) state_d = StLoad;
            end
            StLoad: begin
                ld_actual_o = 1'b1;
                ld_guess_o  = 1'b1;
                state_d     = StCmp;
            end
            StGuess: begin
                ld_guess_o = 1'b1;
                state_d    = StCmp;
            end
            StCmp: begin
                if (flags_onehot) begin
                    over_d     = cmp_gt_i;
                    under_d    = cmp_lt_i;
                    equal_d    = cmp_eq_i;
                    attempts_d = att_next;
                    if (cmp_eq_i)     state_d = StWin;
                    else if (hit_max) state_d = StLose;
                    else              state_d = StWait;
                end else begin
                    // Bad compare: flag it and let the player re-enter the same guess.
                    err_d   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (rise) state_d = StGuess;
            end
            StWin, StLose: begin
                state_d = state_q;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StInit;
            enter_q    <= 1'b0;
            over_q     <= 1'b0;
            under_q    <= 1'b0;
            equal_q    <= 1'b0;
            attempts_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            enter_q    <= enter_i;
            over_q     <= over_d;
            under_q    <= under_d;
            equal_q    <= equal_d;
            attempts_q <= attempts_d;
            err_q      <= err_d;
        end
    end

    assign dp_over_o   = over_q;
    assign dp_under_o  = under_q;
    assign dp_equal_o  = equal_q;
    assign attempts_o  = attempts_q;
    assign err_o       = err_q;
    assign game_over_o = (state_q == StWin) || (state_q == StLose);
    assign lose_o      = (state_q == StLose);

endmodule
